alu_scheduler: RTL and testbench

Two-port arbiter and sequencer for the shared combinational `alu8bit` datapath. It accepts 18-bit ALU instructions from two requesters over valid/ready handshakes and grants them round-robin. It drives the granted instruction onto the ALU and holds it for an opcode-dependent settle time, then captures out, extended_out, overflow and carry into a result register. The result is returned over a valid/ready handshake tagged with the requester id.

---
 rtl/alu_scheduler.sv | 131 +++++++++++++
 tb/tb_alu_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Round-robin arbiter and sequencer in front of the shared combinational
//   alu8bit datapath. Each accepted instruction is held on alu_instruction
//   for an opcode-dependent settle time, after which the ALU outputs are
//   captured and returned tagged with the requester id.
//
// Parameters
//   SETTLE_CYCLES : hold cycles before capture for add/and/xor (1..15)
//   MUL_SETTLE    : hold cycles before capture for mul (1..15)
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   req0_* / req1_*           : valid/ready instruction inputs {op,a,b}
//   alu_instruction           : registered instruction driven to the ALU
//   alu_out/extended_out/
//   alu_overflow/alu_carry    : combinational ALU results
//   res_valid/res_ready       : result handshake
//   res_id                    : requester that issued the result
//   res_out/extended_out/
//   res_overflow/res_carry    : captured ALU results
//   busy                      : high whenever not idle
module alu_scheduler #(
   parameter int SETTLE_CYCLES = 1,
   parameter int MUL_SETTLE    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [17:0] req0_instruction,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [17:0] req1_instruction,
   output logic [17:0] alu_instruction,
   input  logic [7:0]  alu_out,
   input  logic [7:0]  alu_extended_out,
   input  logic        alu_overflow,
   input  logic        alu_carry,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_id,
   output logic [7:0]  res_out,
   output logic [7:0]  res_extended_out,
   output logic        res_overflow,
   output logic        res_carry,
   output logic        busy
);

   localparam logic [3:0] SETTLE_COUNT = 4'(SETTLE_CYCLES);
   localparam logic [3:0] MUL_COUNT    = 4'(MUL_SETTLE);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } state_t;

   state_t      state;
   logic        last_grant;
   logic [3:0]  count;
   logic        grant;
   logic        accept;
   logic [17:0] granted_instruction;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Readies are suppressed during reset so a coincident handshake never transfers.
   assign req0_ready = (state == IDLE) & ~reset & req0_valid & ~grant;
   assign req1_ready = (state == IDLE) & ~reset & req1_valid &  grant;
   assign accept     = req0_ready | req1_ready;

   assign granted_instruction = grant ? req1_instruction : req0_instruction;
   assign busy                = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         count            <= '0;
         alu_instruction  <= '0;
         res_valid        <= 1'b0;
         res_id           <= 1'b0;
         res_out          <= '0;
         res_extended_out <= '0;
         res_overflow     <= 1'b0;
         res_carry        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_instruction <= granted_instruction;
                  res_id          <= grant;
                  last_grant      <= grant;
                  count           <= (granted_instruction[17:16] == 2'b11) ? MUL_COUNT
                                                                           : SETTLE_COUNT;
                  state           <= SETTLE;
               end
            end
            SETTLE: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  res_out          <= alu_out;
                  res_extended_out <= alu_extended_out;
                  res_overflow     <= alu_overflow;
                  res_carry        <= alu_carry;
                  res_valid        <= 1'b1;
                  state            <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Directed scenarios followed by a randomized run against a transaction-level
//   model of the scheduler. A behavioural stand-in for alu8bit sits on the
//   ALU port and computes results with plain arithmetic.
module tb_alu_scheduler;

   localparam int S_ALU = 1;
   localparam int S_MUL = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [17:0] req0_instruction, req1_instruction;
   logic [17:0] alu_instruction;
   logic [7:0]  alu_out, alu_extended_out;
   logic        alu_overflow, alu_carry;
   logic        res_valid, res_ready, res_id;
   logic [7:0]  res_out, res_extended_out;
   logic        res_overflow, res_carry;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_scheduler #(.SETTLE_CYCLES(S_ALU), .MUL_SETTLE(S_MUL)) dut (
      .clk              (clk),
      .reset            (reset),
      .req0_valid       (req0_valid),
      .req0_ready       (req0_ready),
      .req0_instruction (req0_instruction),
      .req1_valid       (req1_valid),
      .req1_ready       (req1_ready),
      .req1_instruction (req1_instruction),
      .alu_instruction  (alu_instruction),
      .alu_out          (alu_out),
      .alu_extended_out (alu_extended_out),
      .alu_overflow     (alu_overflow),
      .alu_carry        (alu_carry),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_id           (res_id),
      .res_out          (res_out),
      .res_extended_out (res_extended_out),
      .res_overflow     (res_overflow),
      .res_carry        (res_carry),
      .busy             (busy)
   );

   // Returns {overflow, carry, extended_out, out} for an instruction.
   function automatic logic [17:0] ref_alu(input logic [17:0] ins);
      logic [7:0]  a, b, o, e;
      logic        ov, cy;
      logic [8:0]  s;
      logic [15:0] p;
      a  = ins[15:8];
      b  = ins[7:0];
      o  = '0;
      e  = '0;
      ov = 1'b0;
      cy = 1'b0;
      case (ins[17:16])
         2'b00: begin
            s  = {1'b0, a} + {1'b0, b};
            o  = s[7:0];
            cy = s[8];
            ov = (a[7] == b[7]) && (o[7] != a[7]);
         end
         2'b01: o = a & b;
         2'b10: o = a ^ b;
         default: begin
            p  = a * b;
            o  = p[7:0];
            e  = p[15:8];
            ov = (e != 8'h00);
         end
      endcase
      return {ov, cy, e, o};
   endfunction

   always_comb begin
      {alu_overflow, alu_carry, alu_extended_out, alu_out} = ref_alu(alu_instruction);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic id, input logic [7:0] o,
                          input logic [7:0] e, input logic ov, input logic cy);
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_id"}, res_id, id);
      chk({tag, "_out"}, res_out, o);
      chk({tag, "_ext"}, res_extended_out, e);
      chk({tag, "_ovf"}, res_overflow, ov);
      chk({tag, "_carry"}, res_carry, cy);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   // Transaction-level model state for the randomized run.
   bit          pend [2];
   logic [17:0] pend_ins [2];
   bit          m_free, m_done, m_last, m_id;
   int          m_wait;
   logic [17:0] m_cur, m_alu;
   logic [17:0] m_res;
   bit          rst, e0, e1, w;

   initial begin
      reset            = 1'b0;
      req0_valid       = 1'b0;
      req1_valid       = 1'b0;
      req0_instruction = '0;
      req1_instruction = '0;
      res_ready        = 1'b0;

      // Reset values
      do_reset();
      #1;
      chk("rst_alu_ins", alu_instruction, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_out", res_out, 0);
      chk("rst_res_ext", res_extended_out, 0);
      chk("rst_res_ovf", res_overflow, 0);
      chk("rst_res_carry", res_carry, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);

      // Single add 1 + 7
      req0_valid = 1'b1;
      req0_instruction = 18'h00107;
      res_ready = 1'b1;
      #1;
      chk("add_rdy0", req0_ready, 1);
      chk("add_rdy1", req1_ready, 0);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("add_busy", busy, 1);
      chk("add_alu_ins", alu_instruction, 18'h00107);
      chk("add_rdy0_off", req0_ready, 0);
      chk("add_valid_early", res_valid, 0);
      cyc();
      chk_res("add_res", 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
      cyc();
      chk("add_valid_clr", res_valid, 0);
      chk("add_idle", busy, 0);
      chk("add_alu_hold", alu_instruction, 18'h00107);

      // Tie after reset: req0 wins first, req1 accepted 3 cycles later
      do_reset();
      res_ready = 1'b1;
      req0_valid = 1'b1;
      req0_instruction = 18'h1140F;
      req1_valid = 1'b1;
      req1_instruction = 18'h20FF0;
      #1;
      chk("tie_rdy0", req0_ready, 1);
      chk("tie_rdy1", req1_ready, 0);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("tie_rdy1_busy", req1_ready, 0);
      cyc();
      chk_res("tie_res0", 1'b0, 8'h04, 8'h00, 1'b0, 1'b0);
      chk("tie_rdy1_done", req1_ready, 0);
      cyc();
      chk("tie_rdy1_grant", req1_ready, 1);
      chk("tie_valid_clr", res_valid, 0);
      cyc();
      req1_valid = 1'b0;
      #1;
      chk("tie_alu_ins1", alu_instruction, 18'h20FF0);
      chk("tie_id1_early", res_id, 1);
      cyc();
      chk_res("tie_res1", 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
      cyc();

      // Mul latency 3 * 7 on req1
      req1_valid = 1'b1;
      req1_instruction = 18'h30307;
      #1;
      chk("mul_rdy1", req1_ready, 1);
      cyc();
      req1_valid = 1'b0;
      #1;
      chk("mul_valid_t1", res_valid, 0);
      cyc();
      chk("mul_valid_t1b", res_valid, 0);
      chk("mul_busy", busy, 1);
      cyc();
      chk_res("mul_res", 1'b1, 8'h15, 8'h00, 1'b0, 1'b0);
      cyc();
      chk("mul_valid_clr", res_valid, 0);

      // Backpressure: result held 5 cycles while req0 keeps asking
      res_ready = 1'b0;
      req0_valid = 1'b1;
      req0_instruction = 18'h00503;
      #1;
      chk("bp_rdy0", req0_ready, 1);
      cyc();
      req0_instruction = 18'h0FF01;
      #1;
      chk("bp_rdy0_off", req0_ready, 0);
      cyc();
      chk_res("bp_res", 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_res("bp_hold", 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
         chk("bp_hold_rdy0", req0_ready, 0);
         chk("bp_hold_busy", busy, 1);
         chk("bp_hold_alu", alu_instruction, 18'h00503);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_rdy0_in_hs", req0_ready, 0);
      cyc();
      chk("bp_valid_clr", res_valid, 0);
      chk("bp_rdy0_next", req0_ready, 1);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("bp_alu_ins2", alu_instruction, 18'h0FF01);
      cyc();
      chk_res("bp_res2", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc();

      // Reset one cycle into a mul; req0 stays valid and is re-accepted
      req0_valid = 1'b1;
      req0_instruction = 18'h30A0B;
      #1;
      chk("rm_rdy0", req0_ready, 1);
      cyc();
      reset = 1'b1;
      #1;
      chk("rm_rdy0_settle", req0_ready, 0);
      cyc();
      reset = 1'b0;
      #1;
      chk("rm_valid", res_valid, 0);
      chk("rm_alu_ins", alu_instruction, 0);
      chk("rm_busy", busy, 0);
      chk("rm_res_out", res_out, 0);
      chk("rm_res_ext", res_extended_out, 0);
      chk("rm_rdy0_again", req0_ready, 1);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("rm_alu_ins2", alu_instruction, 18'h30A0B);
      chk("rm_valid_t1", res_valid, 0);
      cyc();
      chk("rm_valid_t1b", res_valid, 0);
      cyc();
      chk_res("rm_res", 1'b0, 8'h6E, 8'h00, 1'b0, 1'b0);
      cyc();

      // Reset coincident with a would-be handshake: nothing transfers
      req0_valid = 1'b1;
      req0_instruction = 18'h00203;
      reset = 1'b1;
      #1;
      chk("rh_rdy0", req0_ready, 0);
      cyc();
      reset = 1'b0;
      req0_valid = 1'b0;
      #1;
      chk("rh_busy", busy, 0);
      chk("rh_alu_ins", alu_instruction, 0);

      // Randomized run against the transaction model
      do_reset();
      m_free = 1'b1;
      m_done = 1'b0;
      m_last = 1'b1;
      m_id   = 1'b0;
      m_wait = 0;
      m_cur  = '0;
      m_alu  = '0;
      m_res  = '0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
               pend[r]     = 1'b1;
               pend_ins[r] = 18'($urandom);
            end
         end
         reset            = rst;
         req0_valid       = pend[0];
         req1_valid       = pend[1];
         req0_instruction = pend[0] ? pend_ins[0] : 18'($urandom);
         req1_instruction = pend[1] ? pend_ins[1] : 18'($urandom);
         res_ready        = ($urandom_range(0, 3) != 0);
         #1;
         e0 = !rst && m_free && pend[0] && (!pend[1] || m_last);
         e1 = !rst && m_free && pend[1] && (!pend[0] || !m_last);
         chk("rnd_rdy0", req0_ready, e0);
         chk("rnd_rdy1", req1_ready, e1);
         chk("rnd_busy", busy, !m_free);
         chk("rnd_valid", res_valid, m_done);
         chk("rnd_id", res_id, m_id);
         chk("rnd_alu_ins", alu_instruction, m_alu);
         chk("rnd_res", {res_overflow, res_carry, res_extended_out, res_out}, m_res);
         if (rst) begin
            m_free = 1'b1;
            m_done = 1'b0;
            m_last = 1'b1;
            m_id   = 1'b0;
            m_alu  = '0;
            m_res  = '0;
         end else if (e0 || e1) begin
            w       = e1;
            m_cur   = pend_ins[w];
            m_alu   = m_cur;
            m_id    = w;
            m_last  = w;
            m_wait  = (m_cur[17:16] == 2'b11) ? S_MUL : S_ALU;
            m_free  = 1'b0;
            pend[w] = 1'b0;
         end else if (!m_free && !m_done) begin
            m_wait--;
            if (m_wait == 0) begin
               m_done = 1'b1;
               m_res  = ref_alu(m_cur);
            end
         end else if (m_done && res_ready) begin
            m_done = 1'b0;
            m_free = 1'b1;
         end
         cyc();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
